// File: rtl/bus_if_pkg.sv
// rtl/bus_if_pkg.sv - shared defaults and byte-merge helper for bus_if
package bus_if_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;
    localparam int MERGE_W    = 64;

    // Widest supported word; callers zero-extend narrower words and take the low bits back.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_word,
        input logic [MERGE_W-1:0]   new_word,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_W / 8; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bus_if_chg_det.sv
// rtl/bus_if_chg_det.sv - registered change pulse and previous-value capture
module bus_if_chg_det
    import bus_if_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] cur_data,
    input  logic [DATA_W-1:0] next_data,
    output logic              changed,
    output logic [DATA_W-1:0] prev_data
);

    logic differs;
    assign differs = (next_data != cur_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed   <= 1'b0;
            prev_data <= RST_VAL;
        end else begin
            changed <= differs;
            if (differs) begin
                prev_data <= cur_data;
            end
        end
    end

endmodule

// File: rtl/bus_if.sv
// rtl/bus_if.sv - byte-enabled shared data register with write counter and change detect
module bus_if
    import bus_if_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   data,
    output logic [DATA_W-1:0]   prev_data,
    output logic                changed,
    output logic [CNT_W-1:0]    wr_count
);

    logic [MERGE_W-1:0] merged;
    logic [DATA_W-1:0]  next_data;
    logic               unused_merge;

    assign merged       = byte_merge(MERGE_W'(data), MERGE_W'(wr_data), (MERGE_W/8)'(wr_be));
    assign unused_merge = ^merged;
    assign next_data    = wr_en ? merged[DATA_W-1:0] : data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= RST_VAL;
            wr_count <= '0;
        end else begin
            data <= next_data;
            if (wr_en) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

    bus_if_chg_det #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_chg_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .cur_data  (data),
        .next_data (next_data),
        .changed   (changed),
        .prev_data (prev_data)
    );

endmodule

// File: tb/tb_bus_if.sv
// tb/tb_bus_if.sv - randomized self-checking bench for bus_if against a mask-based model
module tb_bus_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_be = 2'b00;
    logic [15:0] wr_data = 16'h0000;
    logic [15:0] data;
    logic [15:0] prev_data;
    logic        changed;
    logic [7:0]  wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_data;
    logic [15:0] m_prev;
    logic        m_changed;
    int          m_count;

    bus_if #(
        .DATA_W  (16),
        .RST_VAL (16'h0000),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .data      (data),
        .prev_data (prev_data),
        .changed   (changed),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},     32'(data),      32'(m_data));
        check({tag, ".prev"},     32'(prev_data), 32'(m_prev));
        check({tag, ".changed"},  32'(changed),   32'(m_changed));
        check({tag, ".wr_count"}, 32'(wr_count),  32'(m_count));
    endtask

    task automatic model_reset();
        m_data    = 16'h0000;
        m_prev    = 16'h0000;
        m_changed = 1'b0;
        m_count   = 0;
    endtask

    // One clock: drive, let the edge happen, advance the model, compare 1ns later.
    task automatic cycle(input logic en, input logic [1:0] be, input logic [15:0] d, input string tag);
        logic [15:0] mask;
        logic [15:0] nw;
        wr_en   = en;
        wr_be   = be;
        wr_data = d;
        @(posedge clk);
        nw = m_data;
        if (en) begin
            mask = (be[0] ? 16'h00ff : 16'h0000) | (be[1] ? 16'hff00 : 16'h0000);
            nw = (m_data & ~mask) | (d & mask);
            m_count = (m_count + 1) % 256;
        end
        m_changed = (nw != m_data);
        if (m_changed) m_prev = m_data;
        m_data = nw;
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");

        rst_n = 1'b1;
        cycle(1'b0, 2'b00, 16'h0000, "post_reset_idle");

        cycle(1'b1, 2'b11, 16'hdead, "w_dead");
        check("dead.data", 32'(data), 32'h0000dead);
        check("dead.changed", 32'(changed), 32'd1);
        cycle(1'b1, 2'b11, 16'hbeef, "w_beef");
        check("beef.prev", 32'(prev_data), 32'h0000dead);
        check("beef.changed", 32'(changed), 32'd1);
        cycle(1'b1, 2'b11, 16'hbeef, "w_beef_same");
        check("beef_same.changed", 32'(changed), 32'd0);
        check("beef_same.count", 32'(wr_count), 32'd3);
        cycle(1'b1, 2'b01, 16'h1234, "w_lo_byte");
        check("lo_byte.data", 32'(data), 32'h0000be34);
        cycle(1'b1, 2'b00, 16'hffff, "w_no_be");
        check("no_be.count", 32'(wr_count), 32'd5);
        cycle(1'b0, 2'b11, 16'h5555, "idle_hold");

        // Counter wrap: one write, then 255 more.
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 2'b11, 16'($urandom), "wrap_first");
        for (int i = 0; i < 255; i++) begin
            cycle(1'b1, 2'($urandom), 16'($urandom), "wrap_run");
        end
        check("wrap.count", 32'(wr_count), 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 3) == 0) ? data : 16'($urandom);
            cycle(1'($urandom), 2'($urandom), d, "rand");
        end

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");

        // Write pending across an edge while in reset is discarded.
        wr_en   = 1'b1;
        wr_be   = 2'b11;
        wr_data = 16'hcafe;
        @(posedge clk);
        #1;
        check_all("reset_mid_write");
        rst_n = 1'b1;
        cycle(1'b0, 2'b00, 16'h0000, "deassert_no_pulse");
        cycle(1'b1, 2'b11, 16'h5a5a, "first_after_reset");
        check("first_after_reset.data", 32'(data), 32'h00005a5a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
